// File: rtl/seq_det_pkg.sv
// Shared types, default sizes and width helpers for the multi-pattern serial detector.
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_NUM_PAT = 4;
    localparam int DEF_CNT_W   = 16;

    // ST_FILL: not enough fresh bits yet (or slot disabled); ST_RUN: comparing every bit
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } det_state_t;

    // Width needed to hold a pattern length 0..max_len
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Width needed to select one of num_pat slots
    function automatic int idx_w(input int num_pat);
        return (num_pat > 1) ? $clog2(num_pat) : 1;
    endfunction

endpackage

// File: rtl/seq_detector_multi_if.sv
// Control/status bundle of the programmable pattern detector.
// Optional feature macro: SEQDET_TIMESTAMP_EN adds last_match_idx.
interface seq_detector_multi_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int NUM_PAT = DEF_NUM_PAT,
    parameter int CNT_W   = DEF_CNT_W
) ();

    localparam int LEN_W = len_w(MAX_LEN);
    localparam int IDX_W = idx_w(NUM_PAT);

    logic               input_valid;
    logic               input_seq;
    logic [IDX_W-1:0]   lookfor_seq;
    logic               overlap_en;
    logic               pat_wr_en;
    logic [IDX_W-1:0]   pat_wr_idx;
    logic [MAX_LEN-1:0] pat_wr_data;
    logic [LEN_W-1:0]   pat_wr_len;
    logic               count_clr;
    logic               seq_detected;
    logic [CNT_W-1:0]   seq_count;
    logic               count_sat;
`ifdef SEQDET_TIMESTAMP_EN
    logic [31:0]        last_match_idx;

    modport master (
        output input_valid, input_seq, lookfor_seq, overlap_en,
               pat_wr_en, pat_wr_idx, pat_wr_data, pat_wr_len, count_clr,
        input  seq_detected, seq_count, count_sat, last_match_idx
    );

    modport slave (
        input  input_valid, input_seq, lookfor_seq, overlap_en,
               pat_wr_en, pat_wr_idx, pat_wr_data, pat_wr_len, count_clr,
        output seq_detected, seq_count, count_sat, last_match_idx
    );
`else
    modport master (
        output input_valid, input_seq, lookfor_seq, overlap_en,
               pat_wr_en, pat_wr_idx, pat_wr_data, pat_wr_len, count_clr,
        input  seq_detected, seq_count, count_sat
    );

    modport slave (
        input  input_valid, input_seq, lookfor_seq, overlap_en,
               pat_wr_en, pat_wr_idx, pat_wr_data, pat_wr_len, count_clr,
        output seq_detected, seq_count, count_sat
    );
`endif

endinterface

// File: rtl/seq_det_slot_bank.sv
// Pattern slot register file: one clamped write port, one asynchronous read port.
module seq_det_slot_bank
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int NUM_PAT = DEF_NUM_PAT,
    localparam int LEN_W  = len_w(MAX_LEN),
    localparam int IDX_W  = idx_w(NUM_PAT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [MAX_LEN-1:0] wr_data,
    input  logic [LEN_W-1:0]   wr_len,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [MAX_LEN-1:0] rd_data,
    output logic [LEN_W-1:0]   rd_len
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] data_mem [NUM_PAT];
    logic [LEN_W-1:0]   len_mem  [NUM_PAT];
    logic [LEN_W-1:0]   wr_len_clamped;

    // Lengths beyond the slot capacity are stored as the full capacity
    always_comb begin
        wr_len_clamped = (wr_len > LEN_MAX) ? LEN_MAX : wr_len;
    end

    // Slot storage; reset leaves every slot disabled (len 0)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PAT; i++) begin
                data_mem[i] <= '0;
                len_mem[i]  <= '0;
            end
        end else if (wr_en) begin
            data_mem[wr_idx] <= wr_data;
            len_mem[wr_idx]  <= wr_len_clamped;
        end
    end

    assign rd_data = data_mem[rd_idx];
    assign rd_len  = len_mem[rd_idx];

endmodule

// File: rtl/seq_detector_multi.sv
// Programmable serial pattern detector with NUM_PAT runtime-writable slots,
// overlap control, input qualifier and saturating match counter.
// Optional feature macro: SEQDET_TIMESTAMP_EN (accepted-bit index of the last match).
// A bit arriving in the same cycle as a flush is not accepted: history and
// the accepted-bit index are left untouched that cycle.
module seq_detector_multi
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int NUM_PAT = DEF_NUM_PAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic               clk,
    input logic               reset,
    seq_detector_multi_if.slave bus
);

    localparam int LEN_W = len_w(MAX_LEN);
    localparam int IDX_W = idx_w(NUM_PAT);
    localparam int BIT_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_LEN-1:0] cur_data;
    logic [LEN_W-1:0]   cur_len;

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    det_state_t         state;
    logic [IDX_W-1:0]   lookfor_q;
    logic               seq_detected_q;
    logic [CNT_W-1:0]   count_q;
    logic               sat_q;

    logic               flush;
    logic               accept;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   fill_upd;
    logic               bits_ok;
    logic [BIT_W-1:0]   pos;
    logic               match;

    seq_det_slot_bank #(
        .MAX_LEN (MAX_LEN),
        .NUM_PAT (NUM_PAT)
    ) u_slots (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.pat_wr_en),
        .wr_idx  (bus.pat_wr_idx),
        .wr_data (bus.pat_wr_data),
        .wr_len  (bus.pat_wr_len),
        .rd_idx  (bus.lookfor_seq),
        .rd_data (cur_data),
        .rd_len  (cur_len)
    );

    // Post-shift history/fill and the match decision against the active slot
    always_comb begin
        flush     = (bus.lookfor_seq != lookfor_q) ||
                    (bus.pat_wr_en && (bus.pat_wr_idx == bus.lookfor_seq));
        accept    = bus.input_valid && !flush;
        hist_next = accept ? {hist[MAX_LEN-2:0], bus.input_seq} : hist;
        fill_next = (accept && (fill != LEN_MAX)) ? fill + LEN_W'(1) : fill;
        bits_ok   = 1'b1;
        pos       = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k < int'(cur_len)) begin
                pos = BIT_W'(int'(cur_len) - 1 - k);
                if (cur_data[k] != hist_next[pos]) begin
                    bits_ok = 1'b0;
                end
            end
        end
        match     = accept && (cur_len != '0) && (fill_next >= cur_len) && bits_ok;
        if (flush || (match && !bus.overlap_en)) begin
            fill_upd = '0;
        end else begin
            fill_upd = fill_next;
        end
    end

    // Detector FSM with history, fill and the registered match pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_FILL;
            hist           <= '0;
            fill           <= '0;
            lookfor_q      <= '0;
            seq_detected_q <= 1'b0;
        end else begin
            lookfor_q      <= bus.lookfor_seq;
            hist           <= hist_next;
            fill           <= fill_upd;
            seq_detected_q <= match;
            case (state)
                ST_FILL: begin
                    if ((cur_len != '0) && (fill_upd >= cur_len)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush || (match && !bus.overlap_en) || (cur_len == '0)) begin
                        state <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    // Saturating match counter; a clear beats a simultaneous match
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (bus.count_clr) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (match && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
            if (count_q == (CNT_MAX - CNT_W'(1))) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign bus.seq_detected = seq_detected_q;
    assign bus.seq_count    = count_q;
    assign bus.count_sat    = sat_q;

`ifdef SEQDET_TIMESTAMP_EN
    logic [31:0] bit_idx;
    logic [31:0] last_idx;

    // Free-running accepted-bit index and the index of the last matching bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx  <= '0;
            last_idx <= '0;
        end else begin
            if (accept) begin
                bit_idx <= bit_idx + 32'd1;
            end
            if (match) begin
                last_idx <= bit_idx;
            end
        end
    end

    assign bus.last_match_idx = last_idx;
`endif

endmodule
